lod_decode: RTL and testbench
=============================

# lod_decode

Reassembles the nibble-wise codes produced by the 4-bit leading one detectors into a full-width result. It accepts a stream of per-nibble codes (hot flag plus 2-bit index), most significant nibble first, and emits three things per word: the one-hot mask of the word's leading one, its bit position, and a hot flag. It sits downstream of the LOD4 array, on the consumer side of the nibble-code interface, and drives a valid/ready result channel.

## Interface
- NIBBLES, 4: nibble beats per word; power of two, 2..8; word width W = 4*NIBBLES, index width IW = clog2(W)
- aclk  input  1  clock; all logic on rising edge
- aresetn  input  1  reset, synchronous, active-low
- rx_valid  input  1  nibble code present
- rx_ready  output  1  block accepts nibble code this cycle
- rx_hotflag  input  1  nibble contained a one
- rx_data  input  2  leading-one index within nibble (3 = nibble MSB); ignored when rx_hotflag=0
- tx_valid  output  1  result present
- tx_ready  input  1  consumer accepts result
- tx_data  output  W  one-hot mask of leading one; 0 if none
- tx_index  output  IW  bit position of leading one; 0 if none
- tx_hotflag  output  1  word contained a one

## Operation
- Beat accepted when rx_valid && rx_ready. Beat counter k counts 0..NIBBLES-1, then wraps to 0; beat 0 is the most significant nibble.
- First accepted beat of a word with rx_hotflag=1 latches position P = (NIBBLES-1-k)*4 + rx_data and sets the internal found flag.
- Later beats of the same word never alter P.
- On acceptance of beat NIBBLES-1, the result is loaded into the output register, with the final beat's own contribution included:
  - tx_hotflag = found
  - tx_index = P, or 0 if not found
  - tx_data = 1<<P, or 0 if not found
- The same cycle clears found and P and wraps k to 0.
- Output register: tx_valid sets on the load. It clears on tx_valid && tx_ready unless a new load occurs in the same cycle, in which case it stays 1 and the new result replaces the old.
- tx_data, tx_index and tx_hotflag are held stable while tx_valid && !tx_ready.
- Collection of the next word overlaps with the held result: beats 0..NIBBLES-2 are always accepted.
- rx_ready = aresetn && ((k != NIBBLES-1) || !tx_valid || tx_ready). Only the final beat stalls on a full output register.
- Two states, implied by k and tx_valid:
  - COLLECT: output register empty.
  - FULL: output register holds a result.
  - COLLECT→FULL on final-beat accept.
  - FULL→COLLECT on drain without a simultaneous load.
  - FULL→FULL on a simultaneous drain and load.
- Reset mid-word discards the partial word (k, found, P cleared). Reset with tx_valid=1 drops the pending result.

## Timing
- Reset values: tx_valid=0, tx_data=0, tx_index=0, tx_hotflag=0, k=0, found=0. rx_ready=0 while aresetn=0 and 1 in the first cycle after.
- Latency: the final beat accepted at edge t gives tx_valid=1 and a valid result after edge t (visible in cycle t+1).
- Throughput: one beat per cycle sustained when tx_ready=1, i.e. one word per NIBBLES cycles.
- rx_valid bubbles do not advance k.
- rx_ready has a combinational path from tx_ready; there is no path from rx_valid to rx_ready.
- Simultaneous final-beat accept and tx handshake: the old result is consumed and the new result is present on the next cycle with no gap in tx_valid.

## Test plan
- NIBBLES=4, tx_ready=1, beats (0,x),(1,2),(1,3),(0,x) → one cycle after beat 3: tx_valid=1, tx_data=16'h0400, tx_index=10, tx_hotflag=1.
- Four beats all rx_hotflag=0 → tx_valid=1, tx_data=0, tx_index=0, tx_hotflag=0.
- Beat 0 = (1,3), rest arbitrary hot codes → tx_index=15, tx_data=16'h8000. Word with only beat 3 = (1,0) → tx_index=0, tx_data=16'h0001, tx_hotflag=1.
- Backpressure: tx_ready=0 after word A completes; word B beats 0-2 accepted, beat 3 sees rx_ready=0 and outputs hold A. Raise tx_ready → A handshakes and B beat 3 is accepted in the same cycle, tx_valid stays 1, B's result appears next cycle.
- Random rx_valid gaps within a word → same result as the gap-free case; k advances only on accepted beats.
- Assert aresetn=0 for one cycle after two beats of a word, with a result pending → all outputs 0, rx_ready=0 during reset. The next four beats form a fresh word whose result ignores the pre-reset beats.

Source files
------------

// File: rtl/lod_decode.sv
// lod_decode: reassembles per-nibble leading-one codes (MS nibble first) into a word-wide one-hot mask, index and hot flag.
module lod_decode #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES,
  localparam int IW = $clog2(W)
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          rx_valid,
  output logic          rx_ready,
  input  logic          rx_hotflag,
  input  logic [1:0]    rx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [W-1:0]  tx_data,
  output logic [IW-1:0] tx_index,
  output logic          tx_hotflag
);
  localparam int KW = $clog2(NIBBLES);
  logic [KW-1:0] k;
  logic          found;
  logic [IW-1:0] p;
  logic          acc;
  logic          last;
  logic [IW-1:0] pos_now;
  logic          f_eff;
  logic [IW-1:0] p_eff;
  assign last     = k == KW'(NIBBLES - 1);
  assign rx_ready = aresetn && (!last || !tx_valid || tx_ready);
  assign acc      = rx_valid && rx_ready;
  assign pos_now  = IW'((NIBBLES - 1 - int'(k)) * 4 + int'(rx_data));
  // the final beat may itself carry the first one of the word
  assign f_eff    = found || rx_hotflag;
  assign p_eff    = found ? p : pos_now;
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      k          <= '0;
      found      <= 1'b0;
      p          <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      tx_index   <= '0;
      tx_hotflag <= 1'b0;
    end else begin
      if (acc) begin
        k <= last ? '0 : k + 1'b1;
        if (last) begin
          found <= 1'b0;
          p     <= '0;
        end else if (rx_hotflag && !found) begin
          found <= 1'b1;
          p     <= pos_now;
        end
      end
      if (acc && last) begin
        tx_valid   <= 1'b1;
        tx_hotflag <= f_eff;
        tx_index   <= f_eff ? p_eff : '0;
        tx_data    <= f_eff ? W'(1) << p_eff : '0;
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_lod_decode.sv
// tb_lod_decode: table-driven vectors with a result scoreboard, plus backpressure and reset sequences.
module tb_lod_decode;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        rx_hotflag = 1'b0;
  logic [1:0]  rx_data = 2'd0;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [15:0] tx_data;
  logic [3:0]  tx_index;
  logic        tx_hotflag;

  lod_decode #(.NIBBLES(4)) dut (
    .aclk(aclk), .aresetn(aresetn), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_hotflag(rx_hotflag), .rx_data(rx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_index(tx_index), .tx_hotflag(tx_hotflag)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [11:0] beats;
    logic [15:0] data;
    logic [3:0]  idx;
    logic        hot;
  } vec_t;

  vec_t tbl[7];
  vec_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   rand_rdy = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge aclk) begin
    if (aresetn && tx_valid && tx_ready) begin
      if (q.size() == 0) chk("spurious_result", 1, 0);
      else begin
        vec_t e;
        e = q.pop_front();
        chk("tx_data", 32'(tx_data), 32'(e.data));
        chk("tx_index", 32'(tx_index), 32'(e.idx));
        chk("tx_hotflag", 32'(tx_hotflag), 32'(e.hot));
      end
    end
  end

  task automatic send_beat(input logic h, input logic [1:0] d, input int maxgap);
    int n;
    repeat ($urandom_range(0, maxgap)) begin
      @(posedge aclk); #1;
      if (rand_rdy) tx_ready = 1'($urandom);
    end
    rx_valid = 1'b1; rx_hotflag = h; rx_data = d;
    n = 0;
    @(negedge aclk);
    while (!rx_ready && n < 50) begin
      @(posedge aclk); #1;
      if (rand_rdy) tx_ready = 1'($urandom);
      n++;
      @(negedge aclk);
    end
    if (!rx_ready) chk("rx_ready_timeout", 0, 1);
    @(posedge aclk); #1;
    rx_valid = 1'b0; rx_hotflag = 1'($urandom); rx_data = 2'($urandom);
    if (rand_rdy) tx_ready = 1'($urandom);
  endtask

  task automatic send_word(input vec_t v, input int maxgap, input int nb);
    logic [11:0] bb;
    if (nb == 4) q.push_back(v);
    for (int b = 0; b < nb; b++) begin
      bb = v.beats >> (9 - 3 * b);
      send_beat(bb[2], bb[1:0], maxgap);
    end
  endtask

  initial begin
    int t0, n;
    logic [11:0] bb;
    tbl[0] = '{{3'b000, 3'b110, 3'b111, 3'b000}, 16'h0400, 4'd10, 1'b1};
    tbl[1] = '{{3'b011, 3'b010, 3'b001, 3'b000}, 16'h0000, 4'd0,  1'b0};
    tbl[2] = '{{3'b111, 3'b101, 3'b100, 3'b110}, 16'h8000, 4'd15, 1'b1};
    tbl[3] = '{{3'b000, 3'b011, 3'b000, 3'b100}, 16'h0001, 4'd0,  1'b1};
    tbl[4] = '{{3'b000, 3'b000, 3'b101, 3'b111}, 16'h0020, 4'd5,  1'b1};
    tbl[5] = '{{3'b100, 3'b000, 3'b011, 3'b000}, 16'h1000, 4'd12, 1'b1};
    tbl[6] = '{{3'b010, 3'b100, 3'b011, 3'b000}, 16'h0100, 4'd8,  1'b1};

    @(negedge aclk);
    chk("rx_ready_in_reset", 32'(rx_ready), 0);
    @(posedge aclk); #1;
    chk("reset_tx_valid", 32'(tx_valid), 0);
    chk("reset_tx_data", 32'(tx_data), 0);
    chk("reset_tx_index", 32'(tx_index), 0);
    chk("reset_tx_hotflag", 32'(tx_hotflag), 0);
    aresetn = 1'b1; #1;
    chk("rx_ready_after_reset", 32'(rx_ready), 1);

    t0 = cyc;
    send_word(tbl[0], 0, 4);
    chk("throughput_cycles", 32'(cyc - t0), 4);
    chk("latency_tx_valid", 32'(tx_valid), 1);
    @(posedge aclk); #1;
    chk("tx_valid_drains", 32'(tx_valid), 0);
    for (int i = 1; i < 7; i++) send_word(tbl[i], 0, 4);

    // backpressure: A held while B's final beat stalls, then drain+load together
    @(posedge aclk); #1;
    tx_ready = 1'b0;
    send_word(tbl[0], 0, 4);
    send_word(tbl[2], 0, 3);
    q.push_back(tbl[2]);
    bb = tbl[2].beats;
    rx_valid = 1'b1; rx_hotflag = bb[2]; rx_data = bb[1:0];
    repeat (3) begin
      @(negedge aclk);
      chk("final_beat_stalls", 32'(rx_ready), 0);
      chk("hold_tx_index", 32'(tx_index), 10);
      chk("hold_tx_data", 32'(tx_data), 32'h0400);
      @(posedge aclk); #1;
    end
    tx_ready = 1'b1; #1;
    chk("rx_ready_from_tx_ready", 32'(rx_ready), 1);
    @(posedge aclk); #1;
    rx_valid = 1'b0;
    chk("no_gap_tx_valid", 32'(tx_valid), 1);
    chk("new_result_index", 32'(tx_index), 15);
    @(posedge aclk); #1;

    // random gaps and random backpressure
    rand_rdy = 1;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 7; i++) send_word(tbl[i], 3, 4);
    rand_rdy = 0;
    tx_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 100) begin @(posedge aclk); n++; end
    chk("queue_drained", 32'(q.size()), 0);

    // reset mid-word with a result pending
    #1;
    tx_ready = 1'b0;
    send_word(tbl[0], 0, 4);
    send_word(tbl[2], 0, 2);
    aresetn = 1'b0;
    void'(q.pop_back());
    @(negedge aclk);
    chk("rx_ready_in_mid_reset", 32'(rx_ready), 0);
    @(posedge aclk); #1;
    chk("mid_reset_tx_valid", 32'(tx_valid), 0);
    chk("mid_reset_tx_data", 32'(tx_data), 0);
    chk("mid_reset_tx_index", 32'(tx_index), 0);
    chk("mid_reset_tx_hotflag", 32'(tx_hotflag), 0);
    aresetn = 1'b1;
    tx_ready = 1'b1; #1;
    chk("rx_ready_after_mid_reset", 32'(rx_ready), 1);
    send_word(tbl[3], 0, 4);
    n = 0;
    while (q.size() != 0 && n < 20) begin @(posedge aclk); n++; end
    chk("final_queue_drained", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
